// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Multi-cycle MIPS control unit with private IR, memory handshakes,
//            wait-state timeout and illegal-instruction trapping.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
   parameter int DATA_W          = 32,
   parameter int MEM_TIMEOUT     = 15,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ready,
   input  logic              br_cond,
   output logic              ir_wren,
   output logic              pc_wren,
   output logic [1:0]        pc_sel,
   output logic              reg_wren,
   output logic [1:0]        regdst,
   output logic              mem_to_reg,
   output logic              alu_src,
   output logic [3:0]        alu_op,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [DATA_W-1:0] imm,
   output logic [15:0]       beq_off,
   output logic [25:0]       target_addr,
   output logic              shift_ctrl,
   output logic              sign_ctrl,
   output logic              save_pc,
   output logic              retired,
   output logic              illegal,
   output logic              bus_err
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q;
   logic [31:0] ir_q;
   logic        ir_vld_q;
   logic [7:0]  wait_q;
   logic        illegal_q;
   logic        bus_err_q;

   logic [3:0]  dec_alu_op;
   logic [1:0]  dec_regdst;
   logic        dec_alu_src;
   logic        dec_m2r;
   logic        dec_shift;
   logic        dec_sign;
   logic        dec_save_pc;
   logic        dec_zext;
   logic        dec_rs_zero;
   logic        dec_jump;
   logic        dec_branch;
   logic        dec_load;
   logic        dec_store;
   logic        dec_illegal;
   logic        dst_zero;

   // Decode runs off the private IR, so every field is stable from DECODE
   // until the next instruction is captured.
   always_comb begin
      dec_alu_op  = 4'hF;
      dec_regdst  = 2'b00;
      dec_alu_src = 1'b0;
      dec_m2r     = 1'b0;
      dec_shift   = 1'b0;
      dec_sign    = 1'b0;
      dec_save_pc = 1'b0;
      dec_zext    = 1'b0;
      dec_rs_zero = 1'b0;
      dec_jump    = 1'b0;
      dec_branch  = 1'b0;
      dec_load    = 1'b0;
      dec_store   = 1'b0;
      dec_illegal = 1'b0;
      if (ir_vld_q) begin
         case (ir_q[31:26])
            6'b000000: begin
               dec_regdst = 2'b01;
               case (ir_q[5:0])
                  6'b100000: dec_alu_op = 4'b0000;
                  6'b100010: dec_alu_op = 4'b0001;
                  6'b100100: dec_alu_op = 4'b0010;
                  6'b100101: dec_alu_op = 4'b0011;
                  6'b100110: dec_alu_op = 4'b0100;
                  6'b100111: dec_alu_op = 4'b0110;
                  6'b101010: begin dec_alu_op = 4'b1010; dec_sign = 1'b1; end
                  6'b101011: dec_alu_op = 4'b1010;
                  6'b000000: begin dec_alu_op = 4'b1100; dec_shift = 1'b1; dec_rs_zero = 1'b1; end
                  6'b000010: begin dec_alu_op = 4'b1101; dec_shift = 1'b1; dec_rs_zero = 1'b1; end
                  6'b000011: begin dec_alu_op = 4'b1001; dec_shift = 1'b1; dec_rs_zero = 1'b1; end
                  6'b000100: dec_alu_op = 4'b1100;
                  6'b000110: dec_alu_op = 4'b1101;
                  6'b000111: dec_alu_op = 4'b1001;
                  default:   dec_illegal = 1'b1;
               endcase
            end
            6'b001000: begin dec_alu_op = 4'b0000; dec_alu_src = 1'b1; end
            6'b001010: begin dec_alu_op = 4'b1010; dec_alu_src = 1'b1; dec_sign = 1'b1; end
            6'b001011: begin dec_alu_op = 4'b1010; dec_alu_src = 1'b1; end
            6'b100011: begin dec_alu_op = 4'b0000; dec_alu_src = 1'b1; dec_m2r = 1'b1; dec_load = 1'b1; end
            6'b101011: begin dec_alu_op = 4'b0000; dec_alu_src = 1'b1; dec_store = 1'b1; end
            6'b001100: begin dec_alu_op = 4'b0010; dec_alu_src = 1'b1; dec_zext = 1'b1; end
            6'b001101: begin dec_alu_op = 4'b0011; dec_alu_src = 1'b1; dec_zext = 1'b1; end
            6'b001110: begin dec_alu_op = 4'b0100; dec_alu_src = 1'b1; dec_zext = 1'b1; end
            6'b000100: begin dec_alu_op = 4'b0001; dec_branch = 1'b1; end
            6'b000101: begin dec_alu_op = 4'b1110; dec_branch = 1'b1; end
            6'b000110: begin dec_alu_op = 4'b1000; dec_branch = 1'b1; end
            6'b000111: begin dec_alu_op = 4'b1011; dec_branch = 1'b1; end
            6'b000010: dec_jump = 1'b1;
            6'b000011: begin dec_jump = 1'b1; dec_save_pc = 1'b1; dec_regdst = 2'b10; end
            default:   dec_illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (dec_regdst)
         2'b00:   dst_zero = (ir_q[20:16] == 5'd0);
         2'b01:   dst_zero = (ir_q[15:11] == 5'd0);
         default: dst_zero = 1'b0;
      endcase
   end

   // Wait counter is zeroed in every state other than FETCH/MEM, so both are
   // always entered with a fresh count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         ir_vld_q  <= 1'b0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  ir_q     <= imem_rdata;
                  ir_vld_q <= 1'b1;
                  wait_q   <= '0;
                  state_q  <= S_DECODE;
               end else if (wait_q == c_WAIT_LAST) begin
                  bus_err_q <= 1'b1;
                  state_q   <= S_TRAP;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            S_DECODE: begin
               wait_q <= '0;
               if (dec_jump) begin
                  state_q <= S_FETCH;
               end else if (dec_illegal) begin
                  if (TRAP_ON_ILLEGAL) begin
                     illegal_q <= 1'b1;
                     state_q   <= S_TRAP;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               wait_q <= '0;
               if (dec_branch)                  state_q <= S_FETCH;
               else if (dec_load || dec_store)  state_q <= S_MEM;
               else                             state_q <= S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  wait_q  <= '0;
                  state_q <= dec_load ? S_WB : S_FETCH;
               end else if (wait_q == c_WAIT_LAST) begin
                  bus_err_q <= 1'b1;
                  state_q   <= S_TRAP;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            S_WB: begin
               wait_q  <= '0;
               state_q <= S_FETCH;
            end
            S_TRAP:  state_q <= S_TRAP;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   // Strobes are masked by rst so a reset drops requests in the same cycle.
   always_comb begin
      imem_req = 1'b0;
      ir_wren  = 1'b0;
      pc_wren  = 1'b0;
      pc_sel   = 2'b00;
      reg_wren = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retired  = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_wren = 1'b1;
                  pc_wren = 1'b1;
               end
            end
            S_DECODE: begin
               if (dec_jump) begin
                  pc_wren  = 1'b1;
                  pc_sel   = 2'b10;
                  reg_wren = dec_save_pc;
                  retired  = 1'b1;
               end else if (dec_illegal && !TRAP_ON_ILLEGAL) begin
                  retired = 1'b1;
               end
            end
            S_EXEC: begin
               if (dec_branch) begin
                  pc_wren = br_cond;
                  pc_sel  = 2'b01;
                  retired = 1'b1;
               end
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = dec_store;
               retired  = dmem_ready && dec_store;
            end
            S_WB: begin
               reg_wren = !dst_zero;
               retired  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign regdst      = dec_regdst;
   assign mem_to_reg  = dec_m2r;
   assign alu_src     = dec_alu_src;
   assign alu_op      = dec_alu_op;
   assign shift_ctrl  = dec_shift;
   assign sign_ctrl   = dec_sign;
   assign save_pc     = dec_save_pc;
   assign rs          = dec_rs_zero ? 5'd0 : ir_q[25:21];
   assign rt          = ir_q[20:16];
   assign rd          = ir_q[15:11];
   assign shamt       = ir_q[10:6];
   assign beq_off     = ir_q[15:0];
   assign target_addr = ir_q[25:0];
   assign imm         = dec_zext ? {{(DATA_W-16){1'b0}}, ir_q[15:0]}
                                 : {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
   assign illegal     = illegal_q;
   assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Self-checking bench: instruction vector table with scoreboard,
//            plus handshake, timeout, trap and reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control_fsm;

   localparam int MEM_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready, br_cond;
   logic        ir_wren, pc_wren, reg_wren, mem_to_reg, alu_src;
   logic [1:0]  pc_sel, regdst;
   logic [3:0]  alu_op;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm;
   logic [15:0] beq_off;
   logic [25:0] target_addr;
   logic        shift_ctrl, sign_ctrl, save_pc, retired, illegal, bus_err;

   always #5 clk = ~clk;

   multicycle_control_fsm #(
      .DATA_W(32), .MEM_TIMEOUT(MEM_TIMEOUT), .TRAP_ON_ILLEGAL(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .br_cond(br_cond), .ir_wren(ir_wren), .pc_wren(pc_wren), .pc_sel(pc_sel),
      .reg_wren(reg_wren), .regdst(regdst), .mem_to_reg(mem_to_reg),
      .alu_src(alu_src), .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .imm(imm), .beq_off(beq_off), .target_addr(target_addr),
      .shift_ctrl(shift_ctrl), .sign_ctrl(sign_ctrl), .save_pc(save_pc),
      .retired(retired), .illegal(illegal), .bus_err(bus_err)
   );

   typedef struct {
      string       name;
      logic [31:0] ins;
      logic        bc;
      int          dwait;
      int          lat;
      logic        regw;
      logic        pcw;
      logic [1:0]  pcsel;
      logic [3:0]  aluop;
      logic [1:0]  regdst;
      logic        alusrc;
      logic [31:0] imm;
   } vec_t;

   typedef struct packed {
      int          lat;
      int          irw;
      int          dreq;
      int          rdy_cyc;
      int          rw_cyc;
      logic        dwe;
      logic        regw;
      logic        pcw;
      logic [1:0]  pcsel;
      logic [3:0]  aluop;
      logic [1:0]  regdst;
      logic        alusrc;
      logic        m2r;
      logic        savepc;
      logic        shift;
      logic        sign;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] boff;
      logic [25:0] tgt;
   } obs_t;

   int   n_chk  = 0;
   int   n_pass = 0;
   vec_t vecs[14];
   vec_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Runs one instruction from a FETCH cycle until its retire pulse.
   task automatic run(input logic [31:0] ins, input logic bc, input int dwait, output obs_t o);
      int   cyc  = 0;
      int   dcnt = 0;
      logic done = 1'b0;
      o          = '0;
      imem_rdata = ins;
      br_cond    = bc;
      while (!done && cyc < 40) begin
         imem_ready = (cyc == 0);
         dmem_ready = dmem_req && (dcnt == dwait);
         @(negedge clk);
         cyc++;
         if (ir_wren) o.irw++;
         if (dmem_req) begin
            o.dreq++;
            dcnt++;
            if (dmem_we) o.dwe = 1'b1;
            if (dmem_ready) o.rdy_cyc = cyc;
         end
         if (reg_wren) begin
            o.regw   = 1'b1;
            o.rw_cyc = cyc;
         end
         if (cyc > 1 && pc_wren) o.pcw = 1'b1;
         if (retired) begin
            done     = 1'b1;
            o.lat    = cyc;
            o.pcsel  = pc_sel;
            o.aluop  = alu_op;
            o.regdst = regdst;
            o.alusrc = alu_src;
            o.m2r    = mem_to_reg;
            o.savepc = save_pc;
            o.shift  = shift_ctrl;
            o.sign   = sign_ctrl;
            o.imm    = imm;
            o.rs     = rs;
            o.rd     = rd;
            o.shamt  = shamt;
            o.boff   = beq_off;
            o.tgt    = target_addr;
         end
         tick();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   task automatic wait_retire(input string name, input int bound);
      logic seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         if (retired) seen = 1'b1;
         tick();
      end
      chk(name, seen, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   initial begin
      obs_t o;
      //         name      ins           bc   dw lat rw    pcw   sel    alu   rdst   src   imm
      vecs[0]  = '{"add",  32'h00221820, 1'b0, 0, 4, 1'b1, 1'b0, 2'b00, 4'h0, 2'b01, 1'b0, 32'h00001820};
      vecs[1]  = '{"sub",  32'h00223822, 1'b0, 0, 4, 1'b1, 1'b0, 2'b00, 4'h1, 2'b01, 1'b0, 32'h00003822};
      vecs[2]  = '{"nor",  32'h00221827, 1'b0, 0, 4, 1'b1, 1'b0, 2'b00, 4'h6, 2'b01, 1'b0, 32'h00001827};
      vecs[3]  = '{"sra",  32'h000230C3, 1'b0, 0, 4, 1'b1, 1'b0, 2'b00, 4'h9, 2'b01, 1'b0, 32'h000030C3};
      vecs[4]  = '{"ori",  32'h34248000, 1'b0, 0, 4, 1'b1, 1'b0, 2'b00, 4'h3, 2'b00, 1'b1, 32'h00008000};
      vecs[5]  = '{"slti", 32'h2824FFFF, 1'b0, 0, 4, 1'b1, 1'b0, 2'b00, 4'hA, 2'b00, 1'b1, 32'hFFFFFFFF};
      vecs[6]  = '{"addi0",32'h20200005, 1'b0, 0, 4, 1'b0, 1'b0, 2'b00, 4'h0, 2'b00, 1'b1, 32'h00000005};
      vecs[7]  = '{"lw",   32'h8C25FFFC, 1'b0, 3, 8, 1'b1, 1'b0, 2'b00, 4'h0, 2'b00, 1'b1, 32'hFFFFFFFC};
      vecs[8]  = '{"sw",   32'hAC220008, 1'b0, 0, 4, 1'b0, 1'b0, 2'b00, 4'h0, 2'b00, 1'b1, 32'h00000008};
      vecs[9]  = '{"beq0", 32'h10220004, 1'b0, 0, 3, 1'b0, 1'b0, 2'b01, 4'h1, 2'b00, 1'b0, 32'h00000004};
      vecs[10] = '{"beq1", 32'h10220004, 1'b1, 0, 3, 1'b0, 1'b1, 2'b01, 4'h1, 2'b00, 1'b0, 32'h00000004};
      vecs[11] = '{"bne1", 32'h14220004, 1'b1, 0, 3, 1'b0, 1'b1, 2'b01, 4'hE, 2'b00, 1'b0, 32'h00000004};
      vecs[12] = '{"j",    32'h08000040, 1'b0, 0, 2, 1'b0, 1'b1, 2'b10, 4'hF, 2'b00, 1'b0, 32'h00000040};
      vecs[13] = '{"jal",  32'h0C100000, 1'b0, 0, 2, 1'b1, 1'b1, 2'b10, 4'hF, 2'b10, 1'b0, 32'h00000000};

      rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; br_cond = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_alu_op",   alu_op,   4'hF);
      chk("rst_regdst",   regdst,   0);
      chk("rst_imm",      imm,      0);
      chk("rst_illegal",  illegal,  0);
      chk("rst_bus_err",  bus_err,  0);
      chk("rst_retired",  retired,  0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_fetch", imem_req, 1);
      tick();

      for (int i = 0; i < 14; i++) begin
         vec_t e;
         obs_t ob;
         sb_q.push_back(vecs[i]);
         run(vecs[i].ins, vecs[i].bc, vecs[i].dwait, ob);
         e = sb_q.pop_front();
         chk({e.name, "_lat"},    ob.lat,    e.lat);
         chk({e.name, "_regw"},   ob.regw,   e.regw);
         chk({e.name, "_pcw"},    ob.pcw,    e.pcw);
         chk({e.name, "_pcsel"},  ob.pcsel,  e.pcsel);
         chk({e.name, "_aluop"},  ob.aluop,  e.aluop);
         chk({e.name, "_regdst"}, ob.regdst, e.regdst);
         chk({e.name, "_alusrc"}, ob.alusrc, e.alusrc);
         chk({e.name, "_imm"},    ob.imm,    e.imm);
      end

      run(32'h00221820, 1'b0, 0, o);
      chk("add_irw_once", o.irw, 1);
      chk("add_rd",       o.rd,  3);
      chk("add_retire_c", o.rw_cyc, 4);

      run(32'h8C25FFFC, 1'b0, 3, o);
      chk("lw_dreq_cycles", o.dreq,    4);
      chk("lw_dmem_we",     o.dwe,     0);
      chk("lw_ready_cyc",   o.rdy_cyc, 7);
      chk("lw_regw_cyc",    o.rw_cyc,  8);
      chk("lw_mem_to_reg",  o.m2r,     1);
      chk("lw_beq_off",     o.boff,    16'hFFFC);

      run(32'hAC220008, 1'b0, 0, o);
      chk("sw_dmem_we",   o.dwe,  1);
      chk("sw_dreq",      o.dreq, 1);

      run(32'h0C100000, 1'b0, 0, o);
      chk("jal_save_pc",  o.savepc, 1);
      chk("jal_target",   o.tgt,    26'h0100000);
      chk("jal_regw_cyc", o.rw_cyc, 2);

      run(32'h000230C3, 1'b0, 0, o);
      chk("sra_shift_ctrl", o.shift, 1);
      chk("sra_rs_zero",    o.rs,    0);
      chk("sra_shamt",      o.shamt, 3);
      chk("sra_sign",       o.sign,  0);

      run(32'h2824FFFF, 1'b0, 0, o);
      chk("slti_sign", o.sign, 1);

      // Fetch timeout: ready never comes.
      imem_rdata = 32'h20200005;
      imem_ready = 1'b0;
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
         @(negedge clk);
         if (k == MEM_TIMEOUT - 1) begin
            chk("to_last_req",     imem_req, 1);
            chk("to_last_bus_err", bus_err,  0);
         end
         tick();
      end
      @(negedge clk);
      chk("to_bus_err",  bus_err,  1);
      chk("to_req_drop", imem_req, 0);
      tick();
      imem_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("trap_hold_req",  imem_req, 0);
      chk("trap_no_irw",    ir_wren,  0);
      chk("trap_hold_berr", bus_err,  1);
      tick();

      do_reset();
      @(negedge clk);
      chk("rst_clears_berr", bus_err, 0);
      // Ready arrives in the limit cycle: accepted without error.
      imem_rdata = 32'h20200005;
      imem_ready = 1'b0;
      for (int k = 0; k < MEM_TIMEOUT - 1; k++) tick();
      imem_ready = 1'b1;
      @(negedge clk);
      chk("lim_capture", ir_wren, 1);
      tick();
      imem_ready = 1'b0;
      @(negedge clk);
      chk("lim_no_berr", bus_err,  0);
      chk("lim_decode",  imem_req, 0);
      tick();
      wait_retire("lim_retire", 10);

      // Illegal opcode traps and stays trapped.
      imem_rdata = 32'hFC000000;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      @(negedge clk);
      chk("ill_no_retire", retired, 0);
      tick();
      @(negedge clk);
      chk("ill_flag", illegal,  1);
      chk("ill_req",  imem_req, 0);
      tick();
      imem_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("ill_sticky",   illegal,  1);
      chk("ill_no_fetch", ir_wren,  0);
      tick();
      do_reset();
      @(negedge clk);
      chk("ill_rst_clear", illegal,  0);
      chk("ill_rst_fetch", imem_req, 1);
      tick();

      // Reset while waiting in MEM.
      imem_rdata = 32'h8C25FFFC;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("mid_mem_req", dmem_req, 1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drops_dreq", dmem_req, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_dreq",   dmem_req, 0);
      chk("mid_rst_fetch",  imem_req, 1);
      chk("mid_rst_ill",    illegal,  0);
      chk("mid_rst_berr",   bus_err,  0);
      chk("mid_rst_aluop",  alu_op,   4'hF);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
